// File: rtl/mips_exec_pkg.sv
// Shared widths, opcode/funct codes and strobe encodings for the MIPS-subset execute stage.
package mips_exec_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_IN    = 6'h20;
  localparam logic [5:0] OP_OUT   = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [1:0] STROBE_NONE = 2'b00;
  localparam logic [1:0] LW_OP       = 2'b10;
  localparam logic [1:0] SW_OP       = 2'b01;
  localparam logic [1:0] IN_OP       = 2'b10;
  localparam logic [1:0] OUT_OP      = 2'b01;

endpackage

// File: rtl/mips_exec_branch.sv
// Combinational taken/target decision for beq, bne, j, jal and jr.
module mips_exec_branch
  import mips_exec_pkg::*;
#(
  parameter int DW = mips_exec_pkg::DW,
  parameter int AW = mips_exec_pkg::AW
) (
  input  logic [AW-1:0] pc,
  input  logic [DW-1:0] readRs,
  input  logic [DW-1:0] readRt,
  input  logic [AW-1:0] imm_target,
  input  logic [AW-1:0] jump_target,
  input  logic [5:0]    operand,
  input  logic [5:0]    funct,
  output logic          taken,
  output logic [AW-1:0] target
);

  logic [AW-1:0] rel_target;
  logic          equal;

  assign rel_target = pc + AW'(1) + imm_target;
  assign equal      = (readRs == readRt);

  // A not-taken branch reports target 0 so the downstream write lands on $0.
  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (operand)
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          taken  = 1'b1;
          target = readRs[AW-1:0];
        end
      end
      OP_BEQ: begin
        if (equal) begin
          taken  = 1'b1;
          target = rel_target;
        end
      end
      OP_BNE: begin
        if (!equal) begin
          taken  = 1'b1;
          target = rel_target;
        end
      end
      OP_J, OP_JAL: begin
        taken  = 1'b1;
        target = jump_target;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_exec_alu.sv
// Registered execute-stage ALU: decode, compute, and emit write-back/branch/memory/IO controls.
// Define ALU_OVF_EN to add the registered signed-overflow flag ovf that suppresses the write-back.
module mips_exec_alu
  import mips_exec_pkg::*;
#(
  parameter int DW = mips_exec_pkg::DW,
  parameter int AW = mips_exec_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  input  logic [DW-1:0] readRs,
  input  logic [DW-1:0] readRt,
  input  logic [DW-1:0] readRd,
  input  logic [AW-1:0] readRdAddress,
  input  logic [4:0]    shiftNumber,
  input  logic [15:0]   I_immediate,
  input  logic [AW-1:0] readRtAddress,
  input  logic [25:0]   J_immediate,
  input  logic [5:0]    operand,
  input  logic [5:0]    funct,
  output logic [AW-1:0] writeBackAddress,
  output logic [DW-1:0] result,
  output logic          isZero,
  output logic          isBranch,
  output logic          isJAL,
  output logic [1:0]    loadWrite,
  output logic [AW-1:0] loadWriteAddress,
  output logic [1:0]    inOut,
`ifdef ALU_OVF_EN
  output logic          ovf,
`endif
  output logic [AW-1:0] inOutAddress
);

  logic          br_taken;
  logic [AW-1:0] br_target;
  logic [DW-1:0] imm_sext, imm_zext, rs_imm_sum;
  logic [AW-1:0] ret_pc;

  logic          n_valid, n_branch, n_jal, n_ovf;
  logic [DW-1:0] n_result;
  logic [AW-1:0] n_wba, n_lwa, n_ioa;
  logic [1:0]    n_lw, n_io;

  mips_exec_branch #(.DW(DW), .AW(AW)) u_branch (
    .pc          (pc),
    .readRs      (readRs),
    .readRt      (readRt),
    .imm_target  (I_immediate[AW-1:0]),
    .jump_target (J_immediate[AW-1:0]),
    .operand     (operand),
    .funct       (funct),
    .taken       (br_taken),
    .target      (br_target)
  );

  assign imm_sext   = {{(DW-16){I_immediate[15]}}, I_immediate};
  assign imm_zext   = {{(DW-16){1'b0}}, I_immediate};
  assign rs_imm_sum = readRs + imm_sext;
  assign ret_pc     = pc + AW'(1);

  always_comb begin
    n_valid  = 1'b1;
    n_result = '0;
    n_wba    = '0;
    n_branch = 1'b0;
    n_jal    = 1'b0;
    n_lw     = STROBE_NONE;
    n_lwa    = '0;
    n_io     = STROBE_NONE;
    n_ioa    = '0;
    n_ovf    = 1'b0;
    case (operand)
      OP_RTYPE: begin
        n_wba = readRdAddress;
        case (funct)
          FN_ADD: begin
            n_result = readRs + readRt;
            n_ovf    = (readRs[DW-1] == readRt[DW-1]) && (n_result[DW-1] != readRs[DW-1]);
          end
          FN_SUB: begin
            n_result = readRs - readRt;
            n_ovf    = (readRs[DW-1] != readRt[DW-1]) && (n_result[DW-1] != readRs[DW-1]);
          end
          FN_AND: n_result = readRs & readRt;
          FN_OR:  n_result = readRs | readRt;
          FN_SLT: n_result = {{(DW-1){1'b0}}, ($signed(readRs) < $signed(readRt))};
          FN_SLL: n_result = readRt << shiftNumber;
          FN_SRL: n_result = readRt >> shiftNumber;
          FN_SRA: n_result = $unsigned($signed(readRt) >>> shiftNumber);
          FN_JR: begin
            n_branch = br_taken;
            n_wba    = br_target;
          end
          default: n_valid = 1'b0;
        endcase
      end
      OP_ADDI: begin
        n_wba    = readRtAddress;
        n_result = rs_imm_sum;
        n_ovf    = (readRs[DW-1] == imm_sext[DW-1]) && (rs_imm_sum[DW-1] != readRs[DW-1]);
      end
      OP_ANDI: begin n_wba = readRtAddress; n_result = readRs & imm_zext; end
      OP_ORI:  begin n_wba = readRtAddress; n_result = readRs | imm_zext; end
      OP_XORI: begin n_wba = readRtAddress; n_result = readRs ^ imm_zext; end
      OP_LUI:  begin n_wba = readRtAddress; n_result = {I_immediate, {(DW-16){1'b0}}}; end
      OP_BEQ, OP_BNE, OP_J: begin
        n_branch = br_taken;
        n_wba    = br_target;
      end
      OP_JAL: begin
        n_branch = br_taken;
        n_wba    = br_target;
        n_jal    = 1'b1;
        n_result = {{(DW-AW){1'b0}}, ret_pc};
      end
      OP_LW, OP_SW: begin
        n_lw  = (operand == OP_LW) ? LW_OP : SW_OP;
        n_wba = readRtAddress;
        n_lwa = rs_imm_sum[AW-1:0];
      end
      OP_IN, OP_OUT: begin
        n_io  = (operand == OP_IN) ? IN_OP : OUT_OP;
        n_wba = readRtAddress;
        n_ioa = I_immediate[AW-1:0];
      end
      default: n_valid = 1'b0;
    endcase
    if (!n_valid) n_wba = '0;
`ifdef ALU_OVF_EN
    if (n_ovf) n_wba = '0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      writeBackAddress <= '0;
      result           <= '0;
      isZero           <= 1'b0;
      isBranch         <= 1'b0;
      isJAL            <= 1'b0;
      loadWrite        <= STROBE_NONE;
      loadWriteAddress <= '0;
      inOut            <= STROBE_NONE;
      inOutAddress     <= '0;
    end else begin
      writeBackAddress <= n_wba;
      result           <= n_result;
      isZero           <= n_valid && (n_result == '0);
      isBranch         <= n_branch;
      isJAL            <= n_jal;
      loadWrite        <= n_lw;
      loadWriteAddress <= n_lwa;
      inOut            <= n_io;
      inOutAddress     <= n_ioa;
    end
  end

`ifdef ALU_OVF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf <= 1'b0;
    else        ovf <= n_ovf;
  end

  logic unused_bits;
  assign unused_bits = ^{readRd, J_immediate[25:AW]};
`else
  logic unused_bits;
  assign unused_bits = ^{readRd, J_immediate[25:AW], n_ovf};
`endif

endmodule

// File: tb/tb_mips_exec_alu.sv
// Randomized self-checking bench for mips_exec_alu against a behavioural model, plus pinned directed cases.
module tb_mips_exec_alu;

  typedef struct packed {
    logic [4:0]  pc;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] rd;
    logic [4:0]  rd_a;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic [4:0]  rt_a;
    logic [25:0] jimm;
    logic [5:0]  op;
    logic [5:0]  fn;
  } stim_t;

  typedef struct packed {
    logic [4:0]  wba;
    logic [31:0] result;
    logic        zero;
    logic        br;
    logic        jal;
    logic [1:0]  lw;
    logic [4:0]  lwa;
    logic [1:0]  io;
    logic [4:0]  ioa;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        reset;
  stim_t       cur;
  exp_t        exp_q;

  logic [4:0]  writeBackAddress;
  logic [31:0] result;
  logic        isZero, isBranch, isJAL;
  logic [1:0]  loadWrite, inOut;
  logic [4:0]  loadWriteAddress, inOutAddress;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] op_list [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0c,
                               6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h2b};
  logic [5:0] fn_list [9]  = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

  mips_exec_alu dut (
    .clk              (clk),
    .reset            (reset),
    .pc               (cur.pc),
    .readRs           (cur.rs),
    .readRt           (cur.rt),
    .readRd           (cur.rd),
    .readRdAddress    (cur.rd_a),
    .shiftNumber      (cur.sh),
    .I_immediate      (cur.imm),
    .readRtAddress    (cur.rt_a),
    .J_immediate      (cur.jimm),
    .operand          (cur.op),
    .funct            (cur.fn),
    .writeBackAddress (writeBackAddress),
    .result           (result),
    .isZero           (isZero),
    .isBranch         (isBranch),
    .isJAL            (isJAL),
    .loadWrite        (loadWrite),
    .loadWriteAddress (loadWriteAddress),
    .inOut            (inOut),
`ifdef ALU_OVF_EN
    .ovf              (ovf),
`endif
    .inOutAddress     (inOutAddress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural meaning of one instruction, written from the ISA rules.
  function automatic exp_t model(stim_t s);
    exp_t        e = '0;
    bit          ok = 1'b1;
    int unsigned a = s.rs;
    int unsigned b = s.rt;
    int unsigned simm = {{16{s.imm[15]}}, s.imm};
    int          sa = $signed(s.rs);
    int          sb = $signed(s.rt);
    int          si = $signed(simm);
    longint      exact;
    bit          take;
    case (s.op)
      6'h00: begin
        e.wba = s.rd_a;
        case (s.fn)
          6'h20: begin e.result = a + b; exact = longint'(sa) + longint'(sb);
                       e.ovf = (exact != longint'($signed(e.result))); end
          6'h22: begin e.result = a - b; exact = longint'(sa) - longint'(sb);
                       e.ovf = (exact != longint'($signed(e.result))); end
          6'h24: e.result = a & b;
          6'h25: e.result = a | b;
          6'h2a: e.result = (sa < sb) ? 1 : 0;
          6'h00: e.result = b << s.sh;
          6'h02: e.result = b >> s.sh;
          6'h03: e.result = sb >>> s.sh;
          6'h08: begin e.br = 1'b1; e.wba = a % 32; end
          default: ok = 1'b0;
        endcase
      end
      6'h08: begin e.wba = s.rt_a; e.result = a + simm; exact = longint'(sa) + longint'(si);
                   e.ovf = (exact != longint'($signed(e.result))); end
      6'h0c: begin e.wba = s.rt_a; e.result = a & s.imm; end
      6'h0d: begin e.wba = s.rt_a; e.result = a | s.imm; end
      6'h0e: begin e.wba = s.rt_a; e.result = a ^ s.imm; end
      6'h0f: begin e.wba = s.rt_a; e.result = s.imm * 65536; end
      6'h04, 6'h05: begin
        take = (s.op == 6'h04) ? (a == b) : (a != b);
        if (take) begin e.br = 1'b1; e.wba = (s.pc + 1 + (s.imm % 32)) % 32; end
      end
      6'h02: begin e.br = 1'b1; e.wba = s.jimm % 32; end
      6'h03: begin e.br = 1'b1; e.jal = 1'b1; e.wba = s.jimm % 32; e.result = s.pc + 1; end
      6'h23: begin e.lw = 2'b10; e.wba = s.rt_a; e.lwa = (a + simm) % 32; end
      6'h2b: begin e.lw = 2'b01; e.wba = s.rt_a; e.lwa = (a + simm) % 32; end
      6'h20: begin e.io = 2'b10; e.wba = s.rt_a; e.ioa = s.imm % 32; end
      6'h21: begin e.io = 2'b01; e.wba = s.rt_a; e.ioa = s.imm % 32; end
      default: ok = 1'b0;
    endcase
    if (!ok) e = '0;
    else begin
      e.zero = (e.result == 0);
`ifdef ALU_OVF_EN
      if (e.ovf) e.wba = '0;
`endif
    end
    return e;
  endfunction

  function automatic stim_t mk(logic [5:0] op, logic [5:0] fn);
    stim_t s = '0;
    s.op = op;
    s.fn = fn;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.pc   = 5'($urandom);
    s.rs   = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    s.rt   = ($urandom_range(0, 3) == 0) ? s.rs : $urandom;
    s.rd   = $urandom;
    s.rd_a = 5'($urandom);
    s.sh   = 5'($urandom);
    s.imm  = 16'($urandom);
    s.rt_a = 5'($urandom);
    s.jimm = 26'($urandom);
    s.op   = ($urandom_range(0, 15) == 0) ? 6'($urandom) : op_list[$urandom_range(0, 13)];
    s.fn   = ($urandom_range(0, 15) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 8)];
    if (s.op == 6'h03 && s.pc == 5'd31) s.pc = 5'd30;
    return s;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_wba"}, 64'(writeBackAddress), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_zero"}, 64'(isZero), 64'd0);
    check({tag, "_br"}, 64'(isBranch), 64'd0);
    check({tag, "_jal"}, 64'(isJAL), 64'd0);
    check({tag, "_lw"}, 64'(loadWrite), 64'd0);
    check({tag, "_lwa"}, 64'(loadWriteAddress), 64'd0);
    check({tag, "_io"}, 64'(inOut), 64'd0);
    check({tag, "_ioa"}, 64'(inOutAddress), 64'd0);
  endtask

  // Reference pipeline stage: one-cycle latency, asynchronously cleared.
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_q <= '0;
    else        exp_q <= model(cur);
  end

  always @(negedge clk) begin
    check("m_wba", 64'(writeBackAddress), 64'(exp_q.wba));
    check("m_result", 64'(result), 64'(exp_q.result));
    check("m_zero", 64'(isZero), 64'(exp_q.zero));
    check("m_br", 64'(isBranch), 64'(exp_q.br));
    check("m_jal", 64'(isJAL), 64'(exp_q.jal));
    check("m_lw", 64'(loadWrite), 64'(exp_q.lw));
    check("m_lwa", 64'(loadWriteAddress), 64'(exp_q.lwa));
    check("m_io", 64'(inOut), 64'(exp_q.io));
    check("m_ioa", 64'(inOutAddress), 64'(exp_q.ioa));
`ifdef ALU_OVF_EN
    check("m_ovf", 64'(ovf), 64'(exp_q.ovf));
`endif
  end

  task automatic step(stim_t s);
    cur = s;
    @(negedge clk);
  endtask

  initial begin
    stim_t s;
    reset = 1'b0;
    cur   = rand_stim();
    repeat (4) begin
      @(negedge clk);
      check_all_zero("rst_hold");
      cur = rand_stim();
    end
    reset = 1'b1;

    s = mk(6'h08, 6'h00); s.rt_a = 5'd16; s.imm = 16'd3;
    step(s);
    check("addi_result", 64'(result), 64'd3);
    check("addi_wba", 64'(writeBackAddress), 64'd16);
    check("addi_zero", 64'(isZero), 64'd0);

    s = mk(6'h0d, 6'h00); s.rs = 32'd3; s.imm = 16'h000a;
    step(s);
    check("ori_result", 64'(result), 64'h0000000b);

    s = mk(6'h0f, 6'h00); s.imm = 16'd3; s.rt_a = 5'd18;
    step(s);
    check("lui_result", 64'(result), 64'h00030000);
    check("lui_wba", 64'(writeBackAddress), 64'd18);

    s = mk(6'h00, 6'h03); s.rt = 32'h80000000; s.sh = 5'd2;
    step(s);
    check("sra_result", 64'(result), 64'he0000000);
    s.fn = 6'h02;
    step(s);
    check("srl_result", 64'(result), 64'h20000000);

    s = mk(6'h00, 6'h2a); s.rs = 32'hffffffff; s.rt = 32'd1;
    step(s);
    check("slt_result", 64'(result), 64'd1);

    s = mk(6'h05, 6'h00); s.pc = 5'd14; s.imm = 16'd1; s.rs = 32'd11; s.rt = 32'd3;
    step(s);
    check("bne_br", 64'(isBranch), 64'd1);
    check("bne_wba", 64'(writeBackAddress), 64'd16);
    s.op = 6'h04; s.rd_a = 5'd9;
    step(s);
    check("beq_nt_br", 64'(isBranch), 64'd0);
    check("beq_nt_wba", 64'(writeBackAddress), 64'd0);
    check("beq_nt_result", 64'(result), 64'd0);

    s = mk(6'h03, 6'h00); s.pc = 5'd23; s.jimm = 26'h100018;
    step(s);
    check("jal_br", 64'(isBranch), 64'd1);
    check("jal_jal", 64'(isJAL), 64'd1);
    check("jal_wba", 64'(writeBackAddress), 64'd24);
    check("jal_result", 64'(result), 64'd24);

    s = mk(6'h00, 6'h08); s.rs = 32'd29; s.rd_a = 5'd7;
    step(s);
    check("jr_wba", 64'(writeBackAddress), 64'd29);
    check("jr_br", 64'(isBranch), 64'd1);

    s = mk(6'h23, 6'h00); s.imm = 16'd16;
    step(s);
    check("lw_strobe", 64'(loadWrite), 64'h2);
    check("lw_addr", 64'(loadWriteAddress), 64'd16);

    s = mk(6'h20, 6'h00); s.imm = 16'h001f;
    step(s);
    check("in_strobe", 64'(inOut), 64'h2);
    check("in_addr", 64'(inOutAddress), 64'd31);
    s.op = 6'h21; s.imm = 16'd3;
    step(s);
    check("out_strobe", 64'(inOut), 64'h1);
    check("out_addr", 64'(inOutAddress), 64'd3);

    s = mk(6'h00, 6'h00);
    step(s);
    check("nop_wba", 64'(writeBackAddress), 64'd0);
    check("nop_result", 64'(result), 64'd0);
    check("nop_zero", 64'(isZero), 64'd1);

    s = mk(6'h3f, 6'h00); s.rs = 32'h1234; s.rt_a = 5'd5;
    step(s);
    check_all_zero("undef_op");

    for (int i = 0; i < 2000; i++) step(rand_stim());

    s = mk(6'h0f, 6'h00); s.imm = 16'h7777; s.rt_a = 5'd3;
    step(s);
    check("pre_rst_result", 64'(result), 64'h77770000);
    #2 reset = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 300; i++) step(rand_stim());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_exec_alu.md
Name: mips_exec_alu

Overview:
- Registered execute-stage ALU for the 32-entry single-cycle MIPS-subset teaching CPU.
- Decodes operand and funct, then computes the arithmetic, logic, shift or compare result.
- Also produces the write-back address, branch/jump targets, load/store and in/out strobes and addresses.
- Sits between the register-file read and the write-back/PC-update logic; all outputs are registered with 1-cycle latency.

Parameters:
- DW, 32, data width.
- AW, 5, register, data-RAM and PC address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous active-low reset.
- pc  in  AW  current instruction index.
- readRs  in  DW  rs register value.
- readRt  in  DW  rt register value.
- readRd  in  DW  rd register value (unused in computation; carried for interface compatibility).
- readRdAddress  in  AW  instruction[15:11].
- shiftNumber  in  5  instruction[10:6].
- I_immediate  in  16  instruction[15:0].
- readRtAddress  in  AW  instruction[20:16].
- J_immediate  in  26  instruction[25:0].
- operand  in  6  opcode.
- funct  in  6  function field.
- writeBackAddress  out  AW  destination register, or branch/jump target PC.
- result  out  DW  computed value.
- isZero  out  1  result==0.
- isBranch  out  1  PC must load writeBackAddress.
- isJAL  out  1  jal executing.
- loadWrite  out  2  10=lw, 01=sw, 00=none.
- loadWriteAddress  out  AW  data-RAM address.
- inOut  out  2  10=in, 01=out, 00=none.
- inOutAddress  out  AW  I/O data address.

Behaviour:
- Inputs are sampled on every rising clk; outputs are registered and appear 1 cycle later.
- No handshake; an instruction is accepted every cycle.
- While reset=0, all outputs are 0, asynchronously. The first capture occurs on the first rising edge after deassertion. Reset mid-operation discards the in-flight result.
- R-type (op 00): writeBackAddress=readRdAddress.
  - add 20, sub 22: wrap modulo 2^32.
  - and 24, or 25.
  - slt 2a: signed compare, result 1 or 0.
  - sll 00, srl 02: readRt shifted by shiftNumber, logical.
  - sra 03: readRt shifted by shiftNumber, arithmetic.
- jr (funct 08): isBranch=1, writeBackAddress=readRs[4:0], result=0.
- I-type: writeBackAddress=readRtAddress.
  - addi 08: readRs + sign-extended immediate.
  - andi 0c, ori 0d, xori 0e: zero-extended immediate.
  - lui 0f: {imm,16'h0}.
- beq 04 / bne 05: target = pc+1+imm[4:0] modulo 32.
  - Taken: isBranch=1, writeBackAddress=target.
  - Not taken: isBranch=0, writeBackAddress=0, result=0, making the downstream write a $0 no-op.
- j 02: isBranch=1, writeBackAddress=J_immediate[4:0].
- jal 03: as j, plus isJAL=1 and result=pc+1 zero-extended.
- lw 23: loadWrite=10, writeBackAddress=readRtAddress, loadWriteAddress=(readRs+sext(imm))[4:0].
- sw 2b: loadWrite=01, with the same addresses as lw.
- in 20: inOut=10, inOutAddress=imm[4:0].
- out 21: inOut=01, inOutAddress=imm[4:0].
- Strobes are mutually exclusive. For lw, sw, in, out and j, result=0.
- Undefined opcode or funct: all outputs 0, treated as a nop.
- isZero is always the registered (next result==0) flag, including for branch/jump cycles.
- 32'h00000000 decodes as sll $0 and yields result 0, writeBackAddress 0.

Optional Feature:
- Macro ALU_OVF_EN.
- Defined: adds output port ovf (1 bit, registered, reset 0). ovf is set on signed overflow of add, sub or addi. When set, writeBackAddress is forced to 0 so the write is suppressed.
- Undefined: no ovf port; overflow wraps silently.

Decomposition:
- Package mips_exec_pkg holds:
  - opcode and funct localparams;
  - loadWrite/inOut encodings (LW_OP=2'b10, SW_OP=2'b01, IN_OP=2'b10, OUT_OP=2'b01);
  - widths DW, AW.
- Sub-module mips_exec_branch: combinational target/taken logic for beq, bne, j, jal, jr.

Test Plan:
- Reset held 0 with random inputs -> all outputs 0. Release, then apply addi op08 rs=0 rt=16 imm=3 -> next cycle result=3, writeBackAddress=16, isZero=0.
- ori readRs=3 imm=0x000a -> result 0x0000000b. lui imm=3 rt=18 -> result 0x00030000, writeBackAddress 18.
- sra readRt=0x80000000 shift=2 -> 0xE0000000. srl with the same inputs -> 0x20000000. slt readRs=-1 readRt=1 -> 1.
- bne pc=14 imm=1 readRs=11 readRt=3 -> isBranch=1, writeBackAddress=16. beq with unequal operands -> isBranch=0, writeBackAddress=0, result=0.
- jal pc=23 J_immediate=0x100018 -> isBranch=1, isJAL=1, writeBackAddress=24, result=24. jr readRs=29 -> writeBackAddress=29.
- lw readRs=0 imm=16 rt=0 -> loadWrite=10, loadWriteAddress=16. in imm=0x1f -> inOut=10, inOutAddress=31. out imm=3 -> inOut=01, inOutAddress=3. Assert reset mid-stream -> outputs 0 immediately.
